// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the 5-stage MIPS pipeline,
// plus start/busy sequencing of the multi-cycle HI/LO (MDU) unit.
`default_nettype none

module hazard_ctrl #(
  parameter int MDU_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic       branchD,
  input  logic       pcsrcD,
  input  logic       hilo_weD,
  input  logic       hilo_rdD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] waE,
  input  logic       we_regE,
  input  logic       dm2regE,
  input  logic       jumpE,
  input  logic       jrE,
  input  logic       hilo_weE,
  input  logic [4:0] waM,
  input  logic       we_regM,
  input  logic       dm2regM,
  input  logic [4:0] waW,
  input  logic       we_regW,
  output logic       stallF,
  output logic       stallD,
  output logic       flushD,
  output logic       flushE,
  output logic [1:0] fwdAE,
  output logic [1:0] fwdBE,
  output logic       fwdAD,
  output logic       fwdBD,
  output logic       mdu_start,
  output logic       mdu_busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MDU_LAT - 1);

  state_t     state;
  logic [3:0] cnt;

  logic m_wr, w_wr, e_wr, m_ld;
  logic lwstall, brstall, mdustall, stall, redirect, start_now;

  // Writes to r0 are architecturally discarded, so they never create a hazard.
  assign m_wr = we_regM && (waM != 5'd0);
  assign w_wr = we_regW && (waW != 5'd0);
  assign e_wr = we_regE && (waE != 5'd0);
  assign m_ld = dm2regM && (waM != 5'd0);

  assign lwstall  = dm2regE && e_wr && ((waE == rsD) || (waE == rtD));
  assign brstall  = branchD && ((e_wr && ((waE == rsD) || (waE == rtD)))
                             || (m_ld && ((waM == rsD) || (waM == rtD))));
  assign start_now = (state == IDLE) && hilo_weE;
  assign mdustall = (hilo_weD || hilo_rdD) && ((state == BUSY) || start_now);
  assign stall    = lwstall || brstall || mdustall;
  assign redirect = jumpE || jrE;

  // Outputs are forced low while reset is held, independent of the inputs.
  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    fwdAE     = 2'b00;
    fwdBE     = 2'b00;
    fwdAD     = 1'b0;
    fwdBD     = 1'b0;
    mdu_start = 1'b0;
    mdu_busy  = 1'b0;
    if (!rst) begin
      if (m_wr && (waM == rsE))      fwdAE = 2'b10;
      else if (w_wr && (waW == rsE)) fwdAE = 2'b01;
      if (m_wr && (waM == rtE))      fwdBE = 2'b10;
      else if (w_wr && (waW == rtE)) fwdBE = 2'b01;
      fwdAD     = m_wr && (waM == rsD);
      fwdBD     = m_wr && (waM == rtD);
      mdu_start = start_now;
      mdu_busy  = (state == BUSY);
      if (redirect) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else begin
        stallF = stall;
        stallD = stall;
        flushE = stall;
        flushD = pcsrcD && !stall;
      end
    end
  end

  // MDU sequencer; a redirect does not cancel an operation already in flight.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (hilo_weE) begin
            cnt   <= CNT_INIT;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else             state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenario tests for hazard_ctrl with MDU_LAT = 4.
`default_nettype none

module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE, waE, waM, waW;
  logic       branchD, pcsrcD, hilo_weD, hilo_rdD;
  logic       we_regE, dm2regE, jumpE, jrE, hilo_weE;
  logic       we_regM, dm2regM, we_regW;
  logic       stallF, stallD, flushD, flushE, fwdAD, fwdBD, mdu_start, mdu_busy;
  logic [1:0] fwdAE, fwdBE;

  int total = 0;
  int bad   = 0;

  logic [3:0]  ctl;
  logic [11:0] allout;
  assign ctl    = {stallF, stallD, flushD, flushE};
  assign allout = {ctl, fwdAE, fwdBE, fwdAD, fwdBD, mdu_start, mdu_busy};

  hazard_ctrl #(.MDU_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .branchD(branchD), .pcsrcD(pcsrcD),
    .hilo_weD(hilo_weD), .hilo_rdD(hilo_rdD),
    .rsE(rsE), .rtE(rtE), .waE(waE), .we_regE(we_regE), .dm2regE(dm2regE),
    .jumpE(jumpE), .jrE(jrE), .hilo_weE(hilo_weE),
    .waM(waM), .we_regM(we_regM), .dm2regM(dm2regM),
    .waW(waW), .we_regW(we_regW),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .fwdAE(fwdAE), .fwdBE(fwdBE), .fwdAD(fwdAD), .fwdBD(fwdBD),
    .mdu_start(mdu_start), .mdu_busy(mdu_busy)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0; waE = 0; waM = 0; waW = 0;
    branchD = 0; pcsrcD = 0; hilo_weD = 0; hilo_rdD = 0;
    we_regE = 0; dm2regE = 0; jumpE = 0; jrE = 0; hilo_weE = 0;
    we_regM = 0; dm2regM = 0; we_regW = 0;
  endtask

  // Inputs change just after the negedge (the DUT's active edge).
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    jumpE = 1; hilo_weE = 1; we_regM = 1; waM = 5'd3; rsE = 5'd3; rsD = 5'd3;
    nxt(); #1;
    total++;
    if (allout !== 12'd0) begin
      bad++; $display("FAIL reset_outputs: got %b expected %b", allout, 12'd0);
    end
    rst = 1'b0;
    clear_inputs();
    #1;
    total++;
    if (mdu_busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle: mdu_busy got %b expected 0", mdu_busy);
    end
  endtask

  task automatic test_fwd_e();
    nxt(); clear_inputs();
    we_regM = 1; waM = 5'd3; we_regW = 1; waW = 5'd3; rsE = 5'd3; rtE = 5'd7;
    #1;
    total++;
    if (fwdAE !== 2'b10 || fwdBE !== 2'b00) begin
      bad++; $display("FAIL fwd_m_priority: fwdAE/BE got %b/%b expected 10/00", fwdAE, fwdBE);
    end
    nxt(); we_regM = 0; rtE = 5'd3;
    #1;
    total++;
    if (fwdAE !== 2'b01 || fwdBE !== 2'b01) begin
      bad++; $display("FAIL fwd_w: fwdAE/BE got %b/%b expected 01/01", fwdAE, fwdBE);
    end
    nxt(); we_regM = 1; waM = 5'd9; rtE = 5'd9;
    #1;
    total++;
    if (fwdAE !== 2'b01 || fwdBE !== 2'b10) begin
      bad++; $display("FAIL fwd_mixed: fwdAE/BE got %b/%b expected 01/10", fwdAE, fwdBE);
    end
  endtask

  task automatic test_lwstall();
    nxt(); clear_inputs();
    dm2regE = 1; we_regE = 1; waE = 5'd5; rsD = 5'd5; rtD = 5'd6;
    #1;
    total++;
    if (ctl !== 4'b1101) begin
      bad++; $display("FAIL lwstall: ctl got %b expected 1101", ctl);
    end
    nxt(); clear_inputs();
    we_regW = 1; waW = 5'd5; rsE = 5'd5;
    #1;
    total++;
    if (ctl !== 4'b0000 || fwdAE !== 2'b01) begin
      bad++; $display("FAIL lw_after: ctl/fwdAE got %b/%b expected 0000/01", ctl, fwdAE);
    end
  endtask

  task automatic test_branch();
    nxt(); clear_inputs();
    branchD = 1; pcsrcD = 1; rsD = 5'd2; rtD = 5'd4; we_regE = 1; waE = 5'd4;
    #1;
    total++;
    if (ctl !== 4'b1101) begin
      bad++; $display("FAIL brstall_e: ctl got %b expected 1101", ctl);
    end
    nxt(); we_regE = 0; waE = 0; we_regM = 1; waM = 5'd4;
    #1;
    total++;
    if (ctl !== 4'b0010 || fwdBD !== 1'b1 || fwdAD !== 1'b0) begin
      bad++; $display("FAIL br_fwd_taken: ctl/fwdAD/fwdBD got %b/%b/%b expected 0010/0/1",
                      ctl, fwdAD, fwdBD);
    end
    nxt(); dm2regM = 1;
    #1;
    total++;
    if (ctl !== 4'b1101) begin
      bad++; $display("FAIL brstall_load_m: ctl got %b expected 1101", ctl);
    end
  endtask

  task automatic test_mdu();
    nxt(); clear_inputs();
    hilo_weE = 1; hilo_rdD = 1;
    #1;
    total++;
    if (mdu_start !== 1'b1 || mdu_busy !== 1'b0 || ctl !== 4'b1101) begin
      bad++; $display("FAIL mdu_start_cycle: start/busy/ctl got %b/%b/%b expected 1/0/1101",
                      mdu_start, mdu_busy, ctl);
    end
    for (int i = 0; i < 4; i++) begin
      nxt();
      hilo_weE = (i == 1);
      #1;
      total++;
      if (mdu_start !== 1'b0 || mdu_busy !== 1'b1 || ctl !== 4'b1101) begin
        bad++; $display("FAIL mdu_busy_%0d: start/busy/ctl got %b/%b/%b expected 0/1/1101",
                        i, mdu_start, mdu_busy, ctl);
      end
    end
    nxt(); hilo_weE = 0;
    #1;
    total++;
    if (mdu_busy !== 1'b0 || ctl !== 4'b0000) begin
      bad++; $display("FAIL mdu_release: busy/ctl got %b/%b expected 0/0000", mdu_busy, ctl);
    end
  endtask

  task automatic test_redirect();
    nxt(); clear_inputs();
    dm2regE = 1; we_regE = 1; waE = 5'd5; rsD = 5'd5; jumpE = 1;
    #1;
    total++;
    if (ctl !== 4'b0011) begin
      bad++; $display("FAIL redirect_jump: ctl got %b expected 0011", ctl);
    end
    nxt(); jumpE = 0; jrE = 1; pcsrcD = 1;
    #1;
    total++;
    if (ctl !== 4'b0011) begin
      bad++; $display("FAIL redirect_jr: ctl got %b expected 0011", ctl);
    end
  endtask

  task automatic test_rst_mid_busy();
    nxt(); clear_inputs();
    hilo_weE = 1;
    nxt(); hilo_weE = 0;
    nxt();
    #1;
    total++;
    if (mdu_busy !== 1'b1) begin
      bad++; $display("FAIL pre_abort_busy: got %b expected 1", mdu_busy);
    end
    rst = 1'b1; jumpE = 1; hilo_rdD = 1;
    #1;
    total++;
    if (allout !== 12'd0) begin
      bad++; $display("FAIL abort_outputs: got %b expected %b", allout, 12'd0);
    end
    nxt();
    rst = 1'b0; jumpE = 0; hilo_rdD = 0; hilo_weE = 1;
    #1;
    total++;
    if (mdu_start !== 1'b1 || mdu_busy !== 1'b0) begin
      bad++; $display("FAIL fresh_start: start/busy got %b/%b expected 1/0", mdu_start, mdu_busy);
    end
    nxt(); hilo_weE = 0;
    for (int i = 0; i < 4; i++) nxt();
    #1;
    total++;
    if (mdu_busy !== 1'b0) begin
      bad++; $display("FAIL fresh_done: busy got %b expected 0", mdu_busy);
    end
  endtask

  task automatic test_r0();
    nxt(); clear_inputs();
    we_regM = 1; waM = 0; we_regW = 1; waW = 0; rsE = 0; rtE = 0;
    dm2regE = 1; we_regE = 1; waE = 0; rsD = 0; rtD = 0; branchD = 1;
    #1;
    total++;
    if (ctl !== 4'b0000 || fwdAE !== 2'b00 || fwdBE !== 2'b00 || fwdAD !== 1'b0) begin
      bad++; $display("FAIL r0_no_hazard: ctl/fwdAE/fwdBE/fwdAD got %b/%b/%b/%b expected 0000/00/00/0",
                      ctl, fwdAE, fwdBE, fwdAD);
    end
  endtask

  initial begin
    test_reset();
    test_fwd_e();
    test_lwstall();
    test_branch();
    test_mdu();
    test_redirect();
    test_rst_mid_busy();
    test_r0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
